// File: rtl/filter_sample_sequencer.sv
// Sample-rate scheduler: prescaled one-cycle tick, then ADC -> filter -> DAC sequencing with overrun/timeout flags.
// Latency: tick 1 cycle after terminal count; each start/load pulse 1 cycle after its trigger.
// Backpressure: none; ticks arriving while busy are dropped and flagged. Optional SEQ_SAMPLE_COUNT_EN adds a sample counter.
module filter_sample_sequencer #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 666,
  parameter int TO_W        = 8,
  parameter int TO_LIMIT    = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             adc_done,
  input  logic             filt_done,
  input  logic             err_clr,
  output logic             sample_tick,
  output logic             adc_start,
  output logic             filt_start,
  output logic             dac_load,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic [15:0]      sample_count
);

  typedef enum logic [1:0] {S_IDLE, S_ADC_WAIT, S_FILT_WAIT, S_DAC_OUT} state_t;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  state_t           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_adc_start;
  logic             r_filt_start;
  logic             r_dac_load;
  logic             r_overrun;
  logic             r_timeout_err;
  logic             w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_W'(TO_LIMIT - 1));

  // A divisor of 0 would tick every cycle; clamp keeps the period at least 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_div  <= DIV_W'(DIV_DEFAULT);
      r_tick <= 1'b0;
    end else if (div_load) begin
      r_div  <= (div_value == '0) ? DIV_W'(1) : div_value;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == r_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_adc_start   <= 1'b0;
      r_filt_start  <= 1'b0;
      r_dac_load    <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_adc_start  <= 1'b0;
      r_filt_start <= 1'b0;
      r_dac_load   <= 1'b0;
      if (err_clr) begin
        r_overrun     <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      // Later assignments override the clear so a same-cycle set wins.
      if (r_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            r_adc_start <= 1'b1;
            r_to_cnt    <= '0;
            r_state     <= S_ADC_WAIT;
          end
        end
        S_ADC_WAIT: begin
          if (adc_done) begin
            r_filt_start <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= S_FILT_WAIT;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_FILT_WAIT: begin
          if (filt_done) begin
            r_dac_load <= 1'b1;
            r_state    <= S_DAC_OUT;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DAC_OUT: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_tick = r_tick;
  assign adc_start   = r_adc_start;
  assign filt_start  = r_filt_start;
  assign dac_load    = r_dac_load;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

`ifdef SEQ_SAMPLE_COUNT_EN
  logic [15:0] r_sample_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_count <= 16'h0000;
    end else if (r_dac_load) begin
      r_sample_count <= r_sample_count + 16'h0001;
    end
  end

  assign sample_count = r_sample_count;
`else
  assign sample_count = 16'h0000;
`endif

endmodule
